// File: rtl/pipe_skid_rx_if.sv
// pipe_skid_rx_if
// Handshake and data bundle for the receive-side skid buffer.
//   Producer side : i_valid, i_data (delay-line output, no handshake),
//                   o_ready (registered permission back to the producer)
//   Consumer side : o_valid, o_data (FIFO head), i_ready (consumer accept)
//   Status        : o_count (occupancy), o_overflow (sticky drop flag)
// The 'slave' modport is the buffer's view; 'master' is the surrounding logic.
interface pipe_skid_rx_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8
);
  logic                    i_valid;
  logic [DWIDTH-1:0]       i_data;
  logic                    o_ready;
  logic                    o_valid;
  logic [DWIDTH-1:0]       o_data;
  logic                    i_ready;
  logic [$clog2(DEPTH):0]  o_count;
  logic                    o_overflow;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count, o_overflow
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count, o_overflow
  );
endinterface

// File: rtl/pipe_skid_rx.sv
// pipe_skid_rx
// Elastic buffer at the output of a fixed-latency delay line. Every arriving
// beat is captured into a DEPTH-entry circular FIFO; a registered o_ready is
// returned to the producer and drops while LAT trailing beats still fit.
// The consumer side is first-word-fall-through valid/ready.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - pipe_skid_rx_if.slave (i_valid/i_data in, o_ready out,
//            o_valid/o_data/i_ready consumer port, o_count, o_overflow)
//
// Parameters: DWIDTH payload width, DEPTH entries (power of two, >= LAT+2),
//             LAT beats that can still land after o_ready goes low.
//
// Optional feature: define PIPE_SKID_RX_OVERFLOW_EN to build the sticky
// overflow flag and its simulation assertion. Without it o_overflow is 0 and
// overflowing beats are dropped silently.
module pipe_skid_rx #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int LAT    = 3
) (
  input  logic           clk,
  input  logic           reset,
  pipe_skid_rx_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - LAT);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              ready_q,  ready_d;
  logic              push, pop;

  always_comb begin
    pop      = (count_q != '0) && bus.i_ready;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    push     = bus.i_valid && ((count_q != FULL_CNT) || pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // Judged on next occupancy so the LAT in-flight beats always have room.
    ready_d  = (count_d < READY_LIM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data;
  end

  assign bus.o_valid = (count_q != '0);
  assign bus.o_data  = mem_q[rd_ptr_q];
  assign bus.o_count = count_q;
  assign bus.o_ready = ready_q;

`ifdef PIPE_SKID_RX_OVERFLOW_EN
  logic drop;
  logic ovf_q, ovf_d;

  always_comb begin
    drop  = bus.i_valid && (count_q == FULL_CNT) && !pop;
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.o_overflow = ovf_q;

  // A dropped beat means the producer ignored o_ready or LAT is too small.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !drop);
`else
  assign bus.o_overflow = 1'b0;
`endif
endmodule

// File: doc/pipe_skid_rx.md
# pipe_skid_rx

Receive-side elastic buffer for the far end of a fixed-latency delay-line channel. The producer launches beats into a free-running `N`-stage delay line that has no backpressure. This block sits at the delay line's output, captures every arriving beat into a small FIFO, and drives a registered `o_ready` back to the producer. `o_ready` drops early enough that the in-flight beats never overflow the buffer. The consumer side is a standard first-word-fall-through valid/ready port.

## Interface
- `DWIDTH`, 8: payload width in bits.
- `DEPTH`, 8: FIFO entries. Must be a power of two and at least `LAT+2`.
- `LAT`, 3: beats that may still arrive after `o_ready` is first driven low. This is the round trip: ready delay to producer + forward delay-line stages + 1 register cycle.
- `clk` input 1: clock, rising-edge.
- `reset` input 1: reset, asynchronous, active-high. Clock `clk`.
- `i_valid` input 1: beat arriving from the delay line. There is no handshake; it is accepted unconditionally.
- `i_data` input `DWIDTH`: payload arriving with `i_valid`.
- `o_ready` output 1: registered permission for the producer to launch beats.
- `o_valid` output 1: FIFO head valid toward the consumer.
- `o_data` output `DWIDTH`: FIFO head payload.
- `i_ready` input 1: consumer accepts the head when `o_valid && i_ready`.
- `o_count` output `$clog2(DEPTH)+1`: current occupancy.
- `o_overflow` output 1: sticky overflow flag. Present only with the macro in Configuration.

## Operation
- Storage:
  - Circular buffer of `DEPTH` entries with write pointer, read pointer and occupancy `count`.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally modulo `DEPTH`.
- Push: `i_valid` high and `count < DEPTH`, or `count == DEPTH` with a pop in the same cycle.
  - The entry is written at the write pointer, and the write pointer increments.
- Pop: `o_valid && i_ready`.
  - The read pointer increments.
- Occupancy:
  - `count_next = count + push - pop`.
  - Simultaneous push and pop leaves `count` unchanged, including when `count == DEPTH` and when `count == 1`.
- Overflow: `i_valid` while `count == DEPTH` with no pop.
  - The beat is dropped. The write pointer and `count` are unchanged.
  - It is flagged when the feature is enabled.
- Consumer port:
  - `o_valid = (count != 0)` and `o_data = mem[rd_ptr]`.
  - There is no input-to-output bypass.
  - `o_data` is don't-care while `o_valid` is 0.
- Ready generation:
  - `o_ready` is registered: `o_ready <= (count_next < DEPTH - LAT)`.
  - This guarantees that up to `LAT` trailing beats fit.
- Reset values:
  - `o_ready` = 0, `o_valid` = 0, `o_count` = 0, `o_overflow` = 0.
  - Both pointers = 0.
  - Memory contents are not reset.
- Reset mid-operation: all buffered beats are discarded. Beats arriving during reset are ignored.

## Timing
- Latency: a beat with `i_valid` at cycle t gives `o_valid` at t+1, provided the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained.
- `o_ready` reflects occupancy one cycle late. A push at cycle t that reaches `count = DEPTH-LAT` drives `o_ready` low from t+1.
- First cycle after reset release: `o_ready` rises at the first clock edge, since `0 < DEPTH-LAT`.
- `o_count` is registered and updates at the same edge as the pointers.

## Configuration
- Macro: `PIPE_SKID_RX_OVERFLOW_EN`.
- Defined:
  - `o_overflow` is set on the first dropped beat.
  - It holds until `reset`.
  - An assertion fires in simulation.
- Undefined:
  - `o_overflow` is tied to 0 and no detection logic is built.
  - Overflow beats are still silently dropped and `count` never exceeds `DEPTH`.

## Test plan
All scenarios use `DWIDTH=8`, `DEPTH=8`, `LAT=3`.
- Reset release, no traffic -> `o_ready` is 0 during reset and 1 on the first edge after release. `o_valid`=0 and `o_count`=0 throughout.
- Single beat `0xA5` at cycle t with `i_ready`=1 -> `o_valid`=1 and `o_data`=`0xA5` at t+1. `o_count` returns to 0 at t+2.
- Burst of 8 beats (`0x00` to `0x07`) with `i_ready`=0 -> `o_ready` falls the cycle after `count` reaches 5. Final `o_count`=8 with no overflow. Draining returns `0x00` to `0x07` in order and `o_ready` re-rises when `count_next < 5`.
- Full FIFO with simultaneous `i_valid` (`0x55`) and `i_ready` -> head popped, `0x55` written, `o_count` stays 8, `o_overflow` stays 0.
- Full FIFO, `i_valid` (`0xEE`), `i_ready`=0 -> `0xEE` dropped and `o_count`=8. `o_overflow`=1 and sticky with `PIPE_SKID_RX_OVERFLOW_EN`, stays 0 without it. A later drain never yields `0xEE`.
- Continuous push/pop for 20 cycles across the pointer wrap, then `reset` asserted mid-stream -> in-order data before reset. Immediately after reset: `o_valid`=0, `o_count`=0, `o_ready`=0.
